// File: rtl/count_capture.sv
// Event timestamp capture: samples count_in on each rising edge of event_in into a
// show-ahead FIFO that a consumer drains with a valid/ready handshake.
module count_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         count_in,
  input  logic                     event_in,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             event_q;
  logic             ovf_q;

  logic ev_edge;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    ev_edge = event_in & ~event_q;
    pop     = rd_valid & rd_ready;
    // A full FIFO still accepts a capture when the head leaves in the same cycle.
    push    = ev_edge & ((level_q != FULL) | pop);
    drop    = ev_edge & (level_q == FULL) & ~pop;
  end

  // event_q resets high so a level already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      event_q <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      event_q <= event_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop)
        ovf_q <= 1'b1;
      else if (clear_ovf)
        ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= count_in;
  end

  always_comb begin
    rd_valid = (level_q != '0);
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
    level    = level_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_count_capture.sv
// Bench for count_capture: directed vector table, a wrap sequence, then random traffic
// compared against a queue-based model of the capture FIFO.
module tb_count_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] count_in;
  logic             event_in;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       level;
  logic             overflow;
  logic             clear_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  count_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .event_in  (event_in),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       ev;
    logic [7:0] cnt;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [7:0] d;
    logic [2:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  // behavioural model: plain queue of captured values
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_evq;

  task automatic add(input logic r, input logic ev, input logic [7:0] cnt, input logic rdy,
                     input logic clr, input logic v, input logic [7:0] d, input logic [2:0] lvl,
                     input logic ovf);
    vec_t x;
    x = '{r, ev, cnt, rdy, clr, v, d, lvl, ovf};
    tbl.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic ev, input logic [7:0] cnt, input logic rdy,
                       input logic clr);
    bit pop, edg, drop;
    int sz;
    if (!r) begin
      mq.delete();
      m_ovf = 1'b0;
      m_evq = 1'b1;
    end else begin
      sz   = mq.size();
      pop  = (sz != 0) && rdy;
      edg  = ev && !m_evq;
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (edg) begin
        if (sz < DEPTH || pop) mq.push_back(cnt);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      m_evq = ev;
    end
  endtask

  // drive at negedge, let one posedge pass, return at the following negedge
  task automatic step(input logic r, input logic ev, input logic [7:0] cnt, input logic rdy,
                      input logic clr);
    rst       = r;
    event_in  = ev;
    count_in  = cnt;
    rd_ready  = rdy;
    clear_ovf = clr;
    model(r, ev, cnt, rdy, clr);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 32'(mq.size() != 0));
    chk({tag, "_data"},  32'(rd_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
    chk({tag, "_level"}, 32'(level),    32'(mq.size()));
    chk({tag, "_ovf"},   32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    rst = 1'b0; event_in = 1'b1; count_in = '0; rd_ready = 1'b0; clear_ovf = 1'b0;

    // reset with event held high; release must not capture
    add(0,1,8'h00,0,0, 0,8'h00,0,0);
    add(0,1,8'h00,0,0, 0,8'h00,0,0);
    add(1,1,8'h33,0,0, 0,8'h00,0,0);
    add(1,0,8'h33,0,0, 0,8'h00,0,0);
    // single capture and pop; held-high event captures once
    add(1,1,8'h2A,0,0, 1,8'h2A,1,0);
    add(1,1,8'h2B,1,0, 0,8'h00,0,0);
    add(1,0,8'h00,0,0, 0,8'h00,0,0);
    // fill to four, fifth edge dropped
    add(1,1,8'h01,0,0, 1,8'h01,1,0);
    add(1,0,8'h00,0,0, 1,8'h01,1,0);
    add(1,1,8'h02,0,0, 1,8'h01,2,0);
    add(1,0,8'h00,0,0, 1,8'h01,2,0);
    add(1,1,8'h03,0,0, 1,8'h01,3,0);
    add(1,0,8'h00,0,0, 1,8'h01,3,0);
    add(1,1,8'h04,0,0, 1,8'h01,4,0);
    add(1,0,8'h00,0,0, 1,8'h01,4,0);
    add(1,1,8'h05,0,0, 1,8'h01,4,1);
    add(1,0,8'h00,0,0, 1,8'h01,4,1);
    add(1,0,8'h00,0,1, 1,8'h01,4,0);
    // push+pop while full: level stays, no overflow
    add(1,1,8'h09,1,0, 1,8'h02,4,0);
    add(1,0,8'h00,1,0, 1,8'h03,3,0);
    add(1,0,8'h00,1,0, 1,8'h04,2,0);
    add(1,0,8'h00,1,0, 1,8'h09,1,0);
    add(1,0,8'h00,1,0, 0,8'h00,0,0);
    add(1,0,8'h00,1,0, 0,8'h00,0,0);
    // refill, then drop in same cycle as clear: set wins
    add(1,1,8'h0A,0,0, 1,8'h0A,1,0);
    add(1,0,8'h00,0,0, 1,8'h0A,1,0);
    add(1,1,8'h0B,0,0, 1,8'h0A,2,0);
    add(1,0,8'h00,0,0, 1,8'h0A,2,0);
    add(1,1,8'h0C,0,0, 1,8'h0A,3,0);
    add(1,0,8'h00,0,0, 1,8'h0A,3,0);
    add(1,1,8'h0D,0,0, 1,8'h0A,4,0);
    add(1,0,8'h00,0,0, 1,8'h0A,4,0);
    add(1,1,8'h0E,0,1, 1,8'h0A,4,1);
    add(1,0,8'h00,0,1, 1,8'h0A,4,0);
    add(1,0,8'h00,1,0, 1,8'h0B,3,0);
    add(1,0,8'h00,1,0, 1,8'h0C,2,0);
    add(1,0,8'h00,1,0, 1,8'h0D,1,0);
    add(1,0,8'h00,1,0, 0,8'h00,0,0);
    // push+pop at level 1: new entry becomes head, valid stays high
    add(1,1,8'h20,0,0, 1,8'h20,1,0);
    add(1,0,8'h00,0,0, 1,8'h20,1,0);
    add(1,1,8'h21,1,0, 1,8'h21,1,0);
    add(1,0,8'h00,1,0, 0,8'h00,0,0);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].ev, tbl[i].cnt, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_data", i),  32'(rd_data),  32'(tbl[i].d));
      chk($sformatf("vec%0d_level", i), 32'(level),    32'(tbl[i].lvl));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].ovf));
    end

    // ten capture/read pairs so both pointers wrap more than once
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(i), 0, 0);
      chk($sformatf("wrap%0d_data", i),  32'(rd_data), 32'(i));
      chk($sformatf("wrap%0d_level", i), 32'(level),   32'd1);
      step(1, 0, 8'hFF, 1, 0);
      chk($sformatf("wrap%0d_empty", i), 32'(rd_valid), 32'd0);
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 2) != 0),
           8'($urandom),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
